// File: rtl/dm_load_unit.sv
// -----------------------------------------------------------------------------
// dm_load_unit
// Read side of the data memory. The unit takes the word that the DM returns for
// the M-stage address and produces the aligned, sign- or zero-extended load
// result for the W stage. The result is registered on the M->W boundary, so the
// unit has a latency of one cycle. The unit also detects load address errors
// (AdEL) and reports them to the exception path.
//
// Optional feature (macro DEV_RANGE_EN):
//   When DEV_RANGE_EN is defined, word loads (lw) are also legal in two device
//   windows: 0x7F00-0x7F0B and 0x7F10-0x7F1B. Any narrower load in those windows
//   faults. When the macro is undefined, every address >= DM_TOP faults.
//
// Parameters:
//   DM_TOP    first byte address past the DM; a load at or above it faults
//   EXC_ADEL  exception code reported for a load address error
//
// Ports:
//   clk        clock; all state updates on posedge
//   rst        synchronous reset, active high
//   stall      hold all output registers (W-stage freeze)
//   flush      insert a bubble; this wins over stall
//   ld_en      the M-stage instruction is a load
//   ldctr      000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101-111 reserved
//   memaddr    M-stage byte address
//   dm         word read from the DM at memaddr[13:2] in the same cycle
//   pc_m       M-stage PC
//   ld_data    aligned and extended load result
//   ld_valid   ld_data is to be written to the GRF in W
//   exc_valid  the load raised an address error
//   exc_code   EXC_ADEL when exc_valid is set, otherwise 0
//   exc_pc     PC of the faulting load, otherwise 0
//
// Flow control: there is no valid/ready pair. The upstream stage presents one
// candidate load on every cycle. At each posedge the register takes exactly one
// action, chosen by priority: rst, then flush, then stall (hold), then capture.
// The unit has no FSM.
// -----------------------------------------------------------------------------
module dm_load_unit #(
  parameter logic [31:0] DM_TOP   = 32'h0000_3000,
  parameter logic [4:0]  EXC_ADEL = 5'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        ld_en,
  input  logic [2:0]  ldctr,
  input  logic [31:0] memaddr,
  input  logic [31:0] dm,
  input  logic [31:0] pc_m,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_pc
);

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;

  logic [1:0]  offset;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;
  logic        is_word;
  logic        is_half;
  logic        reserved;
  logic        misaligned;
  logic        range_ok;
  logic        fault;

  logic [31:0] nxt_data;
  logic        nxt_valid;
  logic        nxt_exc;
  logic [4:0]  nxt_code;
  logic [31:0] nxt_pc;

`ifdef DEV_RANGE_EN
  logic in_dev;
  // Both window bounds are inclusive. The bounds are full 32-bit unsigned
  // compares, so an address cannot wrap around into a window.
  assign in_dev = ((memaddr >= 32'h0000_7F00) && (memaddr <= 32'h0000_7F0B)) ||
                  ((memaddr >= 32'h0000_7F10) && (memaddr <= 32'h0000_7F1B));
`endif

  always_comb begin
    offset   = memaddr[1:0];
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = dm[7:0];
      2'd1:    byte_sel = dm[15:8];
      2'd2:    byte_sel = dm[23:16];
      default: byte_sel = dm[31:24];
    endcase
    half_sel = offset[1] ? dm[31:16] : dm[15:0];

    is_word  = (ldctr == LD_LW);
    is_half  = (ldctr == LD_LH) || (ldctr == LD_LHU);
    reserved = (ldctr > LD_LBU);

    ext_data = 32'h0;
    case (ldctr)
      LD_LW:   ext_data = dm;
      LD_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  ext_data = {16'h0, half_sel};
      LD_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  ext_data = {24'h0, byte_sel};
      default: ext_data = 32'h0;
    endcase

    misaligned = (is_word && (offset != 2'd0)) || (is_half && offset[0]);

`ifdef DEV_RANGE_EN
    range_ok = (memaddr < DM_TOP) || (in_dev && is_word);
`else
    range_ok = (memaddr < DM_TOP);
`endif

    // A reserved encoding is treated as a non-load, so it never faults.
    fault = ld_en && !reserved && (misaligned || !range_ok);

    nxt_data  = 32'h0;
    nxt_valid = 1'b0;
    nxt_exc   = 1'b0;
    nxt_code  = 5'd0;
    nxt_pc    = 32'h0;
    if (fault) begin
      nxt_exc  = 1'b1;
      nxt_code = EXC_ADEL;
      nxt_pc   = pc_m;
    end else if (ld_en && !reserved) begin
      nxt_data  = ext_data;
      nxt_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ld_data   <= 32'h0;
      ld_valid  <= 1'b0;
      exc_valid <= 1'b0;
      exc_code  <= 5'd0;
      exc_pc    <= 32'h0;
    end else if (!stall) begin
      ld_data   <= nxt_data;
      ld_valid  <= nxt_valid;
      exc_valid <= nxt_exc;
      exc_code  <= nxt_code;
      exc_pc    <= nxt_pc;
    end
  end

endmodule

// File: tb/tb_dm_load_unit.sv
// -----------------------------------------------------------------------------
// tb_dm_load_unit
// Self-checking bench for dm_load_unit. The bench runs in three parts:
//   - a table of single-cycle vectors with hand-derived expected outputs
//   - hand-written sequences for reset, stall and flush
//   - randomized traffic checked against a behavioural model of the load rules
// The bench follows the DEV_RANGE_EN build of the design.
// -----------------------------------------------------------------------------
module tb_dm_load_unit;

  localparam logic [31:0] DM_TOP   = 32'h0000_3000;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam int          W        = 71;

`ifdef DEV_RANGE_EN
  localparam bit DEV_EN = 1'b1;
`else
  localparam bit DEV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, flush, ld_en;
  logic [2:0]  ldctr;
  logic [31:0] memaddr, dm, pc_m;
  logic [31:0] ld_data;
  logic        ld_valid, exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_q;

  dm_load_unit #(.DM_TOP(DM_TOP), .EXC_ADEL(EXC_ADEL)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ld_en(ld_en),
    .ldctr(ldctr), .memaddr(memaddr), .dm(dm), .pc_m(pc_m),
    .ld_data(ld_data), .ld_valid(ld_valid), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_pc(exc_pc)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // packed form used by the bench: {ld_data, ld_valid, exc_valid, exc_code, exc_pc}
  function automatic logic [W-1:0] ok_out(input logic [31:0] d);
    return {d, 1'b1, 1'b0, 5'd0, 32'h0};
  endfunction

  function automatic logic [W-1:0] adel_out(input logic [31:0] pc);
    return {32'h0, 1'b0, 1'b1, EXC_ADEL, pc};
  endfunction

  // Reference model, derived from the load rules by arithmetic on sizes and
  // offsets.
  function automatic logic [W-1:0] model(input logic en, input logic [2:0] op,
                                         input logic [31:0] a, input logic [31:0] w,
                                         input logic [31:0] pc);
    int unsigned size;
    bit sgn, in_dev, legal;
    logic [31:0] v;
    if (!en || op > 3'd4) return '0;
    size = (op == 3'd0) ? 4 : ((op == 3'd1 || op == 3'd2) ? 2 : 1);
    sgn  = (op == 3'd1 || op == 3'd3);
    in_dev = (a >= 32'h7F00 && a <= 32'h7F0B) || (a >= 32'h7F10 && a <= 32'h7F1B);
    legal = (a % size == 0) && ((a < DM_TOP) || (DEV_EN && in_dev && size == 4));
    if (!legal) return adel_out(pc);
    if (size == 4) return ok_out(w);
    if (size == 2) begin
      v = (w >> (8 * (a % 4))) % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = (w >> (8 * (a % 4))) % 256;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end
    return ok_out(v);
  endfunction

  // driver tasks
  task automatic drive(input logic en, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] w, input logic [31:0] pc);
    ld_en = en; ldctr = op; memaddr = a; dm = w; pc_m = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: pop the oldest expected value and compare it with the DUT
  task automatic check(input string name);
    logic [W-1:0] got, exp;
    got = {ld_data, ld_valid, exc_valid, exc_code, exc_pc};
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: no expected value queued", name);
      return;
    end
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got data=%h v=%b ev=%b code=%0d pc=%h, want data=%h v=%b ev=%b code=%0d pc=%h",
               name, got[70:39], got[38], got[37], got[36:32], got[31:0],
               exp[70:39], exp[38], exp[37], exp[36:32], exp[31:0]);
    end
  endtask

  typedef struct {
    string       name;
    logic        en;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] pc;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0);
    tick(); tick();
    exp_q.push_back('0); check("reset_state");
    rst = 1'b0;

    // Vector table: {inputs, expected}.
    vecs.push_back('{"lb_0x13",  1, 3'd3, 32'h13,   32'h8081F2A3, 32'h3000, ok_out(32'hFFFFFF80)});
    vecs.push_back('{"lbu_0x12", 1, 3'd4, 32'h12,   32'h8081F2A3, 32'h3004, ok_out(32'h00000081)});
    vecs.push_back('{"lb_0x10",  1, 3'd3, 32'h10,   32'h8081F2A3, 32'h3008, ok_out(32'hFFFFFFA3)});
    vecs.push_back('{"lh_0x2",   1, 3'd1, 32'h2,    32'h8081F2A3, 32'h300C, ok_out(32'hFFFF8081)});
    vecs.push_back('{"lhu_0x0",  1, 3'd2, 32'h0,    32'h8081F2A3, 32'h3010, ok_out(32'h0000F2A3)});
    vecs.push_back('{"lw_0x4",   1, 3'd0, 32'h4,    32'h8081F2A3, 32'h3014, ok_out(32'h8081F2A3)});
    vecs.push_back('{"lw_0x6",   1, 3'd0, 32'h6,    32'h12345678, 32'h3010, adel_out(32'h3010)});
    vecs.push_back('{"lh_3001",  1, 3'd1, 32'h3001, 32'h12345678, 32'h3018, adel_out(32'h3018)});
    vecs.push_back('{"lw_3000",  1, 3'd0, 32'h3000, 32'h12345678, 32'h301C, adel_out(32'h301C)});
    vecs.push_back('{"lw_2ffc",  1, 3'd0, 32'h2FFC, 32'hCAFEBABE, 32'h3020, ok_out(32'hCAFEBABE)});
    vecs.push_back('{"lw_7f04",  1, 3'd0, 32'h7F04, 32'hDEADBEEF, 32'h3024,
                     DEV_EN ? ok_out(32'hDEADBEEF) : adel_out(32'h3024)});
    vecs.push_back('{"lb_7f04",  1, 3'd3, 32'h7F04, 32'hDEADBEEF, 32'h3028, adel_out(32'h3028)});
    vecs.push_back('{"lw_7f0c",  1, 3'd0, 32'h7F0C, 32'hDEADBEEF, 32'h302C, adel_out(32'h302C)});
    vecs.push_back('{"lw_7f18",  1, 3'd0, 32'h7F18, 32'h01020304, 32'h3030,
                     DEV_EN ? ok_out(32'h01020304) : adel_out(32'h3030)});
    vecs.push_back('{"rsvd_101", 1, 3'd5, 32'h7,    32'h12345678, 32'h3034, '0});
    vecs.push_back('{"rsvd_111", 1, 3'd7, 32'h4,    32'h12345678, 32'h3038, '0});
    vecs.push_back('{"no_load",  0, 3'd0, 32'h4,    32'h12345678, 32'h303C, '0});
    vecs.push_back('{"lhu_7f02", 1, 3'd2, 32'h7F02, 32'h12345678, 32'h3040, adel_out(32'h3040)});

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].op, vecs[i].a, vecs[i].w, vecs[i].pc);
      tick();
      exp_q.push_back(vecs[i].exp);
      check(vecs[i].name);
    end

    // Reset wins over stall while the outputs are nonzero.
    drive(1'b1, 3'd0, 32'h8, 32'h55AA55AA, 32'h3100);
    tick(); exp_q.push_back(ok_out(32'h55AA55AA)); check("pre_rst_capture");
    stall = 1'b1; rst = 1'b1;
    tick(); exp_q.push_back('0); check("rst_over_stall");
    stall = 1'b0; rst = 1'b0;

    // Hold through three stalled cycles while the inputs change, then flush.
    drive(1'b1, 3'd0, 32'hC, 32'hA5A5_0F0F, 32'h3200);
    tick(); exp_q.push_back(ok_out(32'hA5A50F0F)); check("stall_capture");
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd0, 32'h6 + k, $urandom, 32'h3300 + k);
      tick(); exp_q.push_back(ok_out(32'hA5A50F0F)); check($sformatf("stall_hold_%0d", k));
    end
    flush = 1'b1;
    tick(); exp_q.push_back('0); check("stall_flush");
    stall = 1'b0; flush = 1'b0;

    // A fault result also holds under stall.
    drive(1'b1, 3'd1, 32'h5, 32'h0, 32'h3400);
    tick(); exp_q.push_back(adel_out(32'h3400)); check("fault_capture");
    stall = 1'b1; drive(1'b1, 3'd4, 32'h1, 32'hFFFF_FFFF, 32'h3404);
    tick(); exp_q.push_back(adel_out(32'h3400)); check("fault_hold");
    stall = 1'b0;

    // Randomized traffic against the model, including stall, flush and reset.
    model_q = {ld_data, ld_valid, exc_valid, exc_code, exc_pc};
    model_q = adel_out(32'h3400);
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 4))
        0, 1: a = $urandom_range(0, 32'h2FFF);
        2:    a = $urandom_range(32'h7EFC, 32'h7F20);
        3:    a = $urandom_range(32'h2FF8, 32'h3008);
        default: a = $urandom;
      endcase
      drive($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)), a, $urandom, $urandom);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      if (rst || flush) model_q = '0;
      else if (!stall) model_q = model(ld_en, ldctr, memaddr, dm, pc_m);
      tick();
      exp_q.push_back(model_q);
      check("random");
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
